// File: rtl/esp_status_tx.sv
// -----------------------------------------------------------------------------
// esp_status_tx
//
// UART transmitter that reports the smart-home output status (LED / relay
// states) back to the ESP module. Each 8N1 frame carries {HEADER, status}.
// A frame is sent when the synchronised status differs from the last value
// sent, when SEND_REQ_IN is pulsed, or when the optional heartbeat expires.
// Requests that arrive while a frame is on the line collapse into a single
// pending flag, so at most one further frame follows, back-to-back.
//
// Ports:
//   CLK            system clock, rising edge
//   RST_N          synchronous active-low reset
//   STATUS_IN[3:0] status bits, asynchronous to CLK (2-flop synchronised)
//   SEND_REQ_IN    single-cycle synchronous request to send current status
//   ESP_TX_OUT     registered UART line to the ESP, idles high
//   BUSY_OUT       high from the start bit through the end of the stop bit
//   FRAME_CNT_OUT  frames started since reset, wraps 255 -> 0
//   state_dbg      current FSM state (IDLE=0, START=1, DATA=2, STOP=3)
// -----------------------------------------------------------------------------
module esp_status_tx #(
  parameter int unsigned CLKS_PER_BIT     = 5208,
  parameter int unsigned HEARTBEAT_CYCLES = 0,
  parameter logic [3:0]  HEADER           = 4'hA
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] STATUS_IN,
  input  logic       SEND_REQ_IN,
  output logic       ESP_TX_OUT,
  output logic       BUSY_OUT,
  output logic [7:0] FRAME_CNT_OUT,
  output logic [1:0] state_dbg
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  // The heartbeat flags pending one cycle before the counter would reach
  // HEARTBEAT_CYCLES-1, so the next frame's start bit lands exactly
  // HEARTBEAT_CYCLES cycles after the previous frame's stop bit ends.
  localparam int unsigned HB_W = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
  localparam logic [HB_W-1:0] HB_LAST =
    HB_W'((HEARTBEAT_CYCLES > 1) ? (HEARTBEAT_CYCLES - 2) : 0);
  localparam logic HB_EN = (HEARTBEAT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [3:0]        status_meta;
  logic [3:0]        status_s;
  logic [3:0]        sent_snapshot;
  logic              pending;
  logic [7:0]        tx_byte;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [HB_W-1:0]   hb_cnt;

  logic bit_done;
  logic start_frame;
  logic hb_expire;
  logic send_event;
  logic tx_next;

  assign state_dbg = state;
  assign bit_done  = (baud_cnt == BAUD_LAST);

  assign hb_expire  = HB_EN && (state == IDLE) && !pending && (hb_cnt == HB_LAST);
  assign send_event = (status_s != sent_snapshot) || SEND_REQ_IN || hb_expire;

  // Next state, frame-start strobe and next line level.
  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    tx_next     = ESP_TX_OUT;
    case (state)
      IDLE: begin
        if (pending) begin
          state_next  = START;
          start_frame = 1'b1;
          tx_next     = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          state_next = DATA;
          tx_next    = tx_byte[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            tx_next = tx_byte[bit_idx + 3'd1];
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          if (pending) begin
            // Back-to-back: the next start bit follows the stop bit directly.
            state_next  = START;
            start_frame = 1'b1;
            tx_next     = 1'b0;
          end else begin
            state_next = IDLE;
            tx_next    = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      status_meta   <= '0;
      status_s      <= '0;
      sent_snapshot <= '0;
      pending       <= 1'b0;
      tx_byte       <= '0;
      baud_cnt      <= '0;
      bit_idx       <= '0;
      hb_cnt        <= '0;
      ESP_TX_OUT    <= 1'b1;
      BUSY_OUT      <= 1'b0;
      FRAME_CNT_OUT <= '0;
    end else begin
      status_meta <= STATUS_IN;
      status_s    <= status_meta;
      ESP_TX_OUT  <= tx_next;
      BUSY_OUT    <= (state_next != IDLE);

      // Clearing on frame start wins: the frame being started already
      // carries the current status, so a same-cycle request is satisfied.
      if (start_frame) begin
        pending <= 1'b0;
      end else if (send_event) begin
        pending <= 1'b1;
      end

      if (start_frame) begin
        tx_byte       <= {HEADER, status_s};
        sent_snapshot <= status_s;
        FRAME_CNT_OUT <= FRAME_CNT_OUT + 8'd1;
      end

      if (start_frame || state == IDLE || bit_done) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end

      if (state != DATA) begin
        bit_idx <= '0;
      end else if (bit_done) begin
        bit_idx <= bit_idx + 3'd1;
      end

      if (start_frame) begin
        hb_cnt <= '0;
      end else if (HB_EN && state == IDLE && !pending && !hb_expire) begin
        hb_cnt <= hb_cnt + 1'b1;
      end
    end
  end

endmodule
